// File: rtl/data_mem_responder_if.sv
// Request/response channel between the core's data-access port and the memory responder.
// The master modport is the requester (core side) and the slave modport is the memory side.
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [2:0]  req_funct3;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_mem_responder.sv
// Word-organised data RAM with RV32I byte/halfword/word access semantics and a
// configurable number of wait states per access.
module data_mem_responder #(
  parameter int unsigned DEPTH_LOG2  = 6,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);

  localparam int unsigned Depth = 1 << DEPTH_LOG2;
  localparam int unsigned CntW  = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {StIdle, StBusy, StResp} state_e;

  state_e                  state_q;
  logic [CntW-1:0]         cnt_q;
  logic                    write_q;
  logic [31:0]             addr_q;
  logic [2:0]              funct3_q;
  logic [31:0]             wdata_q;
  logic                    rsp_valid_q;
  logic [31:0]             rsp_rdata_q;
  logic                    rsp_err_q;
  logic [31:0]             mem_q [Depth];

  logic                    sel_write;
  logic [31:0]             sel_addr;
  logic [2:0]              sel_funct3;
  logic [31:0]             sel_wdata;
  logic [DEPTH_LOG2-1:0]   widx;
  logic [31:0]             rd_word;
  logic [31:0]             shifted;
  logic                    illegal;
  logic                    misaligned;
  logic                    acc_err;
  logic [31:0]             load_data;
  logic [3:0]              store_be;
  logic [31:0]             store_data;
  logic                    access_now;
  logic                    unused_addr;

  // With zero wait states the access happens on the accept edge, so it must
  // use the live request fields rather than the not-yet-latched copies.
  always_comb begin
    sel_write  = write_q;
    sel_addr   = addr_q;
    sel_funct3 = funct3_q;
    sel_wdata  = wdata_q;
    if (state_q == StIdle) begin
      sel_write  = bus.req_write;
      sel_addr   = bus.req_addr;
      sel_funct3 = bus.req_funct3;
      sel_wdata  = bus.req_wdata;
    end
  end

  assign widx        = sel_addr[DEPTH_LOG2+1:2];
  assign rd_word     = mem_q[widx];
  assign shifted     = rd_word >> {sel_addr[1:0], 3'b000};
  assign unused_addr = ^sel_addr[31:DEPTH_LOG2+2];

  always_comb begin
    if (sel_write) begin
      illegal = (sel_funct3 > 3'd2);
    end else begin
      illegal = (sel_funct3 == 3'd3) || (sel_funct3 == 3'd6) || (sel_funct3 == 3'd7);
    end
    misaligned = ((sel_funct3[1:0] == 2'd1) && sel_addr[0]) ||
                 ((sel_funct3[1:0] == 2'd2) && (sel_addr[1:0] != 2'd0));
    acc_err = illegal || misaligned;
  end

  always_comb begin
    load_data = '0;
    case (sel_funct3)
      3'd0:    load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'd1:    load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'd2:    load_data = shifted;
      3'd4:    load_data = {24'h0, shifted[7:0]};
      3'd5:    load_data = {16'h0, shifted[15:0]};
      default: load_data = '0;
    endcase
  end

  always_comb begin
    store_be   = 4'b0000;
    store_data = sel_wdata;
    case (sel_funct3[1:0])
      2'd0: begin
        store_be   = 4'b0001 << sel_addr[1:0];
        store_data = {4{sel_wdata[7:0]}};
      end
      2'd1: begin
        store_be   = sel_addr[1] ? 4'b1100 : 4'b0011;
        store_data = {2{sel_wdata[15:0]}};
      end
      2'd2: begin
        store_be   = 4'b1111;
        store_data = sel_wdata;
      end
      default: store_be = 4'b0000;
    endcase
  end

  always_comb begin
    access_now = 1'b0;
    if (state_q == StIdle) begin
      access_now = bus.req_valid && (WAIT_CYCLES == 0);
    end else if (state_q == StBusy) begin
      access_now = (cnt_q == '0);
    end
  end

  assign bus.req_ready = (state_q == StIdle) && !rst;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      funct3_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            write_q  <= bus.req_write;
            addr_q   <= bus.req_addr;
            funct3_q <= bus.req_funct3;
            wdata_q  <= bus.req_wdata;
            cnt_q    <= CntW'(WAIT_CYCLES);
            state_q  <= (WAIT_CYCLES == 0) ? StResp : StBusy;
          end
        end
        StBusy: begin
          if (cnt_q == '0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        StResp: begin
          if (bus.rsp_ready) begin
            state_q     <= StIdle;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase

      // Read sample / store commit on the edge that enters StResp.
      if (access_now) begin
        rsp_valid_q <= 1'b1;
        rsp_err_q   <= acc_err;
        rsp_rdata_q <= (sel_write || acc_err) ? 32'h0 : load_data;
        if (sel_write && !acc_err) begin
          for (int b = 0; b < 4; b++) begin
            if (store_be[b]) begin
              mem_q[widx][8*b +: 8] <= store_data[8*b +: 8];
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder: vector table of load/store transactions
// plus hand-written reset, backpressure and mid-access reset sequences.
module tb_data_mem_responder;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  data_mem_responder_if bus ();

  data_mem_responder #(
    .DEPTH_LOG2 (6),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        w;
    logic [31:0] a;
    logic [2:0]  f;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[23];

  // Drives one request, scrambles the inputs after acceptance, waits for the
  // response and completes the handshake with rsp_ready held high.
  task automatic xact(input logic w, input logic [31:0] a, input logic [2:0] f,
                      input logic [31:0] wd, output logic [31:0] rd, output logic er,
                      output int lat);
    int n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = w;
    bus.req_addr   = a;
    bus.req_funct3 = f;
    bus.req_wdata  = wd;
    bus.rsp_ready  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("accept_timeout", 32'd0, 32'd1);
    @(negedge clk);
    bus.req_valid  = 1'b0;
    bus.req_write  = ~w;
    bus.req_addr   = 32'hFFFF_FFFF;
    bus.req_funct3 = 3'd7;
    bus.req_wdata  = $urandom;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    vecs[0]  = '{1'b0, 32'h0000_0000, 3'd2, 32'h0,         32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 32'h0000_0010, 3'd2, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,         32'hDEAD_BEEF, 1'b0};
    vecs[3]  = '{1'b1, 32'h0000_0011, 3'd0, 32'hFFFF_FF55, 32'h0000_0000, 1'b0};
    vecs[4]  = '{1'b0, 32'h0000_0010, 3'd2, 32'h0,         32'hDEAD_55EF, 1'b0};
    vecs[5]  = '{1'b0, 32'h0000_0013, 3'd0, 32'h0,         32'hFFFF_FFDE, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0013, 3'd4, 32'h0,         32'h0000_00DE, 1'b0};
    vecs[7]  = '{1'b0, 32'h0000_0012, 3'd1, 32'h0,         32'hFFFF_DEAD, 1'b0};
    vecs[8]  = '{1'b0, 32'h0000_0012, 3'd5, 32'h0,         32'h0000_DEAD, 1'b0};
    vecs[9]  = '{1'b0, 32'h0000_0011, 3'd0, 32'h0,         32'h0000_0055, 1'b0};
    vecs[10] = '{1'b0, 32'h0000_0010, 3'd1, 32'h0,         32'h0000_55EF, 1'b0};
    vecs[11] = '{1'b1, 32'h0000_0022, 3'd1, 32'hABCD_1234, 32'h0000_0000, 1'b0};
    vecs[12] = '{1'b1, 32'h0000_0022, 3'd2, 32'hCAFE_F00D, 32'h0000_0000, 1'b1};
    vecs[13] = '{1'b0, 32'h0000_0020, 3'd2, 32'h0,         32'h1234_0000, 1'b0};
    vecs[14] = '{1'b0, 32'h0000_0001, 3'd1, 32'h0,         32'h0000_0000, 1'b1};
    vecs[15] = '{1'b0, 32'h0000_0000, 3'd3, 32'h0,         32'h0000_0000, 1'b1};
    vecs[16] = '{1'b1, 32'h0000_0000, 3'd4, 32'h1111_1111, 32'h0000_0000, 1'b1};
    vecs[17] = '{1'b0, 32'h0000_0000, 3'd2, 32'h0,         32'h0000_0000, 1'b0};
    vecs[18] = '{1'b1, 32'h0000_0100, 3'd2, 32'h0BAD_F00D, 32'h0000_0000, 1'b0};
    vecs[19] = '{1'b0, 32'h0000_0000, 3'd2, 32'h0,         32'h0BAD_F00D, 1'b0};
    vecs[20] = '{1'b0, 32'h0000_0010, 3'd6, 32'h0,         32'h0000_0000, 1'b1};
    vecs[21] = '{1'b0, 32'h0000_0013, 3'd2, 32'h0,         32'h0000_0000, 1'b1};
    vecs[22] = '{1'b0, 32'h0000_0100, 3'd4, 32'h0,         32'h0000_000D, 1'b0};

    rst            = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_write  = 1'b0;
    bus.req_addr   = '0;
    bus.req_funct3 = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b0;

    // Reset held for two cycles.
    repeat (2) @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_req_ready", 32'(bus.req_ready), 32'd1);

    for (int i = 0; i < 23; i++) begin
      xact(vecs[i].w, vecs[i].a, vecs[i].f, vecs[i].wd, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'd3);
    end

    // Backpressure: response held with rsp_ready low while another store is offered.
    @(negedge clk);
    bus.rsp_ready  = 1'b0;
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b0;
    bus.req_addr   = 32'h10;
    bus.req_funct3 = 3'd2;
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_wdata = 32'h0;
    n = 0;
    while (!bus.rsp_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    for (int c = 0; c < 5; c++) begin
      check($sformatf("bp_valid%0d", c), 32'(bus.rsp_valid), 32'd1);
      check($sformatf("bp_rdata%0d", c), bus.rsp_rdata, 32'hDEAD_55EF);
      check($sformatf("bp_ready%0d", c), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", 32'(bus.rsp_valid), 32'd0);
    check("bp_release_ready", 32'(bus.req_ready), 32'd1);
    xact(1'b0, 32'h10, 3'd2, 32'h0, rd, er, lat);
    check("bp_store_dropped", rd, 32'hDEAD_55EF);

    // Reset during BUSY of a store aborts it and clears the RAM.
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_write  = 1'b1;
    bus.req_addr   = 32'h30;
    bus.req_funct3 = 3'd2;
    bus.req_wdata  = 32'h1234_5678;
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst           = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_no_rsp", 32'(bus.rsp_valid), 32'd0);
    xact(1'b0, 32'h30, 3'd2, 32'h0, rd, er, lat);
    check("midrst_lw30", rd, 32'h0);
    xact(1'b0, 32'h10, 3'd2, 32'h0, rd, er, lat);
    check("midrst_ram_cleared", rd, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end
endmodule
